neuron_layer_ctrl: RTL and testbench
====================================

# neuron_layer_ctrl

Parametrised sequencer for one fully connected neuron layer. For each of Q neurons it walks D input/weight pairs, issues memory reads, and strobes the datapath accumulator. It then writes each neuron result, optionally through ReLU, and clears the accumulator for the next neuron. It sits between the input/weight memories and the MAC/accumulator datapath, and adds memory-ready and result-sink back-pressure handshakes.

## Interface
- N, 8, datapath word width; passed through for datapath pairing only, no internal arithmetic on it
- D, 16, inputs per neuron (≥1)
- Q, 4, neurons per layer (≥1)
- DW, max(1,$clog2(D)), derived input-index width
- QW, max(1,$clog2(Q)), derived neuron-index width
- WW, max(1,$clog2(D*Q)), derived weight-address width
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- st  in  1  start request; sampled only in IDLE
- relu_en  in  1  mode select; latched when st is accepted
- mem_vld  in  1  memory read data valid; honoured only in FETCH
- res_rdy  in  1  result sink ready; honoured only in WRITE
- busy  out  1  high in every state except IDLE
- mem_rd  out  1  read strobe to x and weight memories
- x_addr  out  DW  input index = d_cnt
- w_addr  out  WW  weight address = q_cnt*D + d_cnt
- acc_write  out  1  accumulate product into accumulator
- res_write  out  1  result write request
- res_addr  out  QW  neuron index = q_cnt
- act_en  out  1  apply ReLU to the written result (= latched relu_en, gated by res_write)
- clear_acc  out  1  zero the accumulator
- done  out  1  one-cycle layer-complete pulse

## Operation
- Internal registers: 3-bit state, d_cnt[DW], q_cnt[QW], mode bit. All outputs are combinational decodes of state and counters.
- IDLE: all strobes low. st=1 → FETCH; d_cnt←0, q_cnt←0, mode←relu_en.
- FETCH: mem_rd=1 with addresses valid. Stay while mem_vld=0. mem_vld=1 → MAC.
- MAC: acc_write=1 for exactly one cycle. If d_cnt==D-1 → WRITE; else d_cnt←d_cnt+1 → FETCH.
- WRITE: res_write=1, res_addr=q_cnt, act_en=mode. Hold all three while res_rdy=0. res_rdy=1 → CLEAR.
- CLEAR: clear_acc=1; d_cnt←0. If q_cnt==Q-1 → DONE; else q_cnt←q_cnt+1 → FETCH.
- DONE: done=1, busy=1 → IDLE unconditionally.
- Unused state encodings → IDLE.
- Counters never wrap: d_cnt tops at D-1 and q_cnt at Q-1, so w_addr never exceeds D*Q-1.
- D=1: MAC goes directly to WRITE. Q=1: CLEAR goes directly to DONE.
- st while busy, including during DONE: ignored, no restart. st high on the cycle after DONE starts a new layer from IDLE.
- relu_en changes mid-layer have no effect.

## Timing
- Reset (rst=0, asynchronous) forces: state=IDLE, counters=0, mode=0, and all outputs 0 (busy, mem_rd, acc_write, res_write, act_en, clear_acc, done, addresses).
- Reset mid-layer aborts immediately. No done pulse; the accumulator clear is the datapath's own reset duty.
- No stalls (mem_vld=res_rdy=1): 2 cycles per input, 2D+2 cycles per neuron.
- If st is accepted at edge E0, done is high in the cycle after edge E0+Q(2D+2). For D=16, Q=4 this is 136 cycles. busy falls one cycle later.
- Each cycle of mem_vld=0 in FETCH or res_rdy=0 in WRITE adds exactly one cycle. Addresses stay stable throughout the stall.
- acc_write is high for exactly D cycles per neuron and clear_acc for exactly 1; they never overlap each other or res_write.

## Test plan
- Reset: hold rst=0 with st=1 → every output 0. Release with st=0 → stays IDLE, busy=0.
- D=4, Q=2, handshakes tied high, st pulse:
  - w_addr sequence is 0,1,2,3,4,5,6,7 on mem_rd cycles.
  - res_addr is 0 then 1.
  - done arrives at E0+20; 8 acc_write and 2 clear_acc pulses total.
- Stall: D=4, Q=2, mem_vld=0 for 3 cycles at d_cnt=2, q_cnt=1 (w_addr=6), and res_rdy=0 for 2 cycles on neuron 0 → mem_rd and w_addr=6 held, res_write held, done delayed exactly 5 cycles to E0+25.
- Mode latch: relu_en=1 at start, driven 0 mid-layer → act_en=1 on both result writes. Repeat with relu_en=0 → act_en=0.
- Boundaries: D=1, Q=1 → FETCH, MAC, WRITE, CLEAR, DONE, with done at E0+4. st held high through the layer and after → exactly one layer per IDLE visit, next layer starts the cycle after DONE.
- Abort: assert rst mid-layer with q_cnt=1, d_cnt=2 → all outputs 0 immediately, no done. A following st runs a full layer from w_addr=0.

Source files
------------

// File: rtl/neuron_layer_ctrl.sv
// Sequencer for one fully connected neuron layer: walks Q neurons x D
// input/weight pairs, strobes the accumulator, writes each neuron result
// (optionally through ReLU) and clears the accumulator between neurons.
module neuron_layer_ctrl #(
  parameter int N  = 8,
  parameter int D  = 16,
  parameter int Q  = 4,
  parameter int DW = (D > 1) ? $clog2(D) : 1,
  parameter int QW = (Q > 1) ? $clog2(Q) : 1,
  parameter int WW = (D * Q > 1) ? $clog2(D * Q) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st,
  input  logic          relu_en,
  input  logic          mem_vld,
  input  logic          res_rdy,
  output logic          busy,
  output logic          mem_rd,
  output logic [DW-1:0] x_addr,
  output logic [WW-1:0] w_addr,
  output logic          acc_write,
  output logic          res_write,
  output logic [QW-1:0] res_addr,
  output logic          act_en,
  output logic          clear_acc,
  output logic          done
);

  // N only sizes the paired datapath; it is checked here so a bad
  // configuration fails at elaboration rather than silently.
  if (N < 1 || D < 1 || Q < 1) begin : g_bad_param
    $error("neuron_layer_ctrl: N, D and Q must all be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   d_cnt_q, d_cnt_d;
  logic [QW-1:0]   q_cnt_q, q_cnt_d;
  logic            mode_q, mode_d;
  logic            d_last;
  logic            q_last;

  // Counters stop at their last index, so they never wrap.
  assign d_last = (d_cnt_q == DW'(D - 1));
  assign q_last = (q_cnt_q == QW'(Q - 1));

  // Next-state and counter update; handshakes only matter in their own state.
  always_comb begin
    state_d = state_q;
    d_cnt_d = d_cnt_q;
    q_cnt_d = q_cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (st) begin
          state_d = S_FETCH;
          d_cnt_d = '0;
          q_cnt_d = '0;
          mode_d  = relu_en;
        end
      end
      S_FETCH: begin
        if (mem_vld) state_d = S_MAC;
      end
      S_MAC: begin
        if (d_last) begin
          state_d = S_WRITE;
        end else begin
          d_cnt_d = d_cnt_q + DW'(1);
          state_d = S_FETCH;
        end
      end
      S_WRITE: begin
        if (res_rdy) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        d_cnt_d = '0;
        if (q_last) begin
          state_d = S_DONE;
        end else begin
          q_cnt_d = q_cnt_q + QW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and latched ReLU mode; reset aborts any layer at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      d_cnt_q <= '0;
      q_cnt_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_cnt_q <= d_cnt_d;
      q_cnt_q <= q_cnt_d;
      mode_q  <= mode_d;
    end
  end

  // Output strobes are pure decodes of the current state and counters.
  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_rd    = (state_q == S_FETCH);
    acc_write = (state_q == S_MAC);
    res_write = (state_q == S_WRITE);
    clear_acc = (state_q == S_CLEAR);
    done      = (state_q == S_DONE);
    act_en    = mode_q & (state_q == S_WRITE);
    x_addr    = d_cnt_q;
    res_addr  = q_cnt_q;
    w_addr    = WW'(q_cnt_q) * WW'(D) + WW'(d_cnt_q);
  end

endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Bench for neuron_layer_ctrl: three configurations (D=4/Q=2, D=1/Q=1,
// D=16/Q=4) checked every cycle against a step-index reference model,
// plus directed scenarios with literal expectations.
module tb_neuron_layer_ctrl;

  localparam int NI = 3;

  typedef struct packed {
    logic [31:0] busy, mem_rd, x_addr, w_addr, acc_write,
                 res_write, res_addr, act_en, clear_acc, done;
  } outs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rstn = '0;
  logic [NI-1:0] st   = '1;
  logic [NI-1:0] rl   = '0;
  logic [NI-1:0] mv   = '1;
  logic [NI-1:0] rr   = '1;

  logic       b0, mr0, aw0, rw0, ae0, ca0, dn0;
  logic [1:0] xa0;
  logic [2:0] wa0;
  logic [0:0] ra0;
  logic       b1, mr1, aw1, rw1, ae1, ca1, dn1;
  logic [0:0] xa1;
  logic [0:0] wa1;
  logic [0:0] ra1;
  logic       b2, mr2, aw2, rw2, ae2, ca2, dn2;
  logic [3:0] xa2;
  logic [5:0] wa2;
  logic [1:0] ra2;

  neuron_layer_ctrl #(.N(8), .D(4), .Q(2)) u_dut0 (
    .clk(clk), .rst(rstn[0]), .st(st[0]), .relu_en(rl[0]), .mem_vld(mv[0]),
    .res_rdy(rr[0]), .busy(b0), .mem_rd(mr0), .x_addr(xa0), .w_addr(wa0),
    .acc_write(aw0), .res_write(rw0), .res_addr(ra0), .act_en(ae0),
    .clear_acc(ca0), .done(dn0));

  neuron_layer_ctrl #(.N(8), .D(1), .Q(1)) u_dut1 (
    .clk(clk), .rst(rstn[1]), .st(st[1]), .relu_en(rl[1]), .mem_vld(mv[1]),
    .res_rdy(rr[1]), .busy(b1), .mem_rd(mr1), .x_addr(xa1), .w_addr(wa1),
    .acc_write(aw1), .res_write(rw1), .res_addr(ra1), .act_en(ae1),
    .clear_acc(ca1), .done(dn1));

  neuron_layer_ctrl #(.N(8), .D(16), .Q(4)) u_dut2 (
    .clk(clk), .rst(rstn[2]), .st(st[2]), .relu_en(rl[2]), .mem_vld(mv[2]),
    .res_rdy(rr[2]), .busy(b2), .mem_rd(mr2), .x_addr(xa2), .w_addr(wa2),
    .acc_write(aw2), .res_write(rw2), .res_addr(ra2), .act_en(ae2),
    .clear_acc(ca2), .done(dn2));

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int dd(int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

  function automatic int qq(int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  function automatic outs_t obs(int i);
    outs_t o;
    o = '0;
    case (i)
      0: begin
        o.busy = 32'(b0); o.mem_rd = 32'(mr0); o.x_addr = 32'(xa0);
        o.w_addr = 32'(wa0); o.acc_write = 32'(aw0); o.res_write = 32'(rw0);
        o.res_addr = 32'(ra0); o.act_en = 32'(ae0); o.clear_acc = 32'(ca0);
        o.done = 32'(dn0);
      end
      1: begin
        o.busy = 32'(b1); o.mem_rd = 32'(mr1); o.x_addr = 32'(xa1);
        o.w_addr = 32'(wa1); o.acc_write = 32'(aw1); o.res_write = 32'(rw1);
        o.res_addr = 32'(ra1); o.act_en = 32'(ae1); o.clear_acc = 32'(ca1);
        o.done = 32'(dn1);
      end
      default: begin
        o.busy = 32'(b2); o.mem_rd = 32'(mr2); o.x_addr = 32'(xa2);
        o.w_addr = 32'(wa2); o.acc_write = 32'(aw2); o.res_write = 32'(rw2);
        o.res_addr = 32'(ra2); o.act_en = 32'(ae2); o.clear_acc = 32'(ca2);
        o.done = 32'(dn2);
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s inst%0d: got %0d, need %0d", name, inst,
                 $signed(act), $signed(exp));
    end
  endtask

  // Reference model: a layer is a flat sequence of Q*(2D+2) steps followed
  // by one done step. Within neuron q, step r<2D is a fetch (even r) or a
  // multiply-accumulate (odd r) of input r/2; r=2D writes, r=2D+1 clears.
  bit m_act  [NI];
  int m_s    [NI];
  bit m_mode [NI];
  int m_id   [NI];
  int m_iq   [NI];

  function automatic outs_t model_out(int i);
    outs_t e;
    int dv, qv, per, s, r, d, q;
    e = '0;
    if (!rstn[i]) return e;
    dv = dd(i); qv = qq(i); per = 2 * dv + 2;
    if (!m_act[i]) begin
      d = m_id[i]; q = m_iq[i];
    end else begin
      e.busy = 1; s = m_s[i];
      if (s == qv * per) begin
        e.done = 1; d = 0; q = qv - 1;
      end else begin
        q = s / per; r = s % per;
        if (r < 2 * dv) begin
          d = r / 2;
          if (r % 2 == 0) e.mem_rd = 1; else e.acc_write = 1;
        end else begin
          d = dv - 1;
          if (r == 2 * dv) begin
            e.res_write = 1; e.act_en = 32'(m_mode[i]);
          end else begin
            e.clear_acc = 1;
          end
        end
      end
    end
    e.x_addr = d; e.w_addr = q * dv + d; e.res_addr = q;
    return e;
  endfunction

  always @(posedge clk) begin
    int dv, qv, per, r;
    bit hold;
    for (int i = 0; i < NI; i++) begin
      dv = dd(i); qv = qq(i); per = 2 * dv + 2;
      if (!rstn[i]) begin
        m_act[i] <= 1'b0; m_s[i] <= 0; m_mode[i] <= 1'b0; m_id[i] <= 0; m_iq[i] <= 0;
      end else if (!m_act[i]) begin
        if (st[i]) begin
          m_act[i] <= 1'b1; m_s[i] <= 0; m_mode[i] <= rl[i];
        end
      end else if (m_s[i] == qv * per) begin
        m_act[i] <= 1'b0; m_id[i] <= 0; m_iq[i] <= qv - 1;
      end else begin
        r = m_s[i] % per;
        hold = (r < 2 * dv && r % 2 == 0 && !mv[i]) || (r == 2 * dv && !rr[i]);
        if (!hold) m_s[i] <= m_s[i] + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs of all instances.
  always @(negedge clk) begin
    outs_t e, o;
    for (int i = 0; i < NI; i++) begin
      e = model_out(i);
      o = obs(i);
      chk("busy", i, o.busy, e.busy);
      chk("mem_rd", i, o.mem_rd, e.mem_rd);
      chk("x_addr", i, o.x_addr, e.x_addr);
      chk("w_addr", i, o.w_addr, e.w_addr);
      chk("acc_write", i, o.acc_write, e.acc_write);
      chk("res_write", i, o.res_write, e.res_write);
      chk("res_addr", i, o.res_addr, e.res_addr);
      chk("act_en", i, o.act_en, e.act_en);
      chk("clear_acc", i, o.clear_acc, e.clear_acc);
      chk("done", i, o.done, e.done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wseq[$];
  int rseq[$];

  // Starts one layer on instance i and follows it to its done cycle.
  task automatic run_layer(input int i, input bit relu0, input bit hold_st,
                           input bit do_stall, input int budget,
                           output int done_k, output int n_acc, output int n_clr,
                           output int n_resw, output int n_act_ok, output int n_w6);
    outs_t o;
    bit prev_rd, prev_rw;
    int sv, sr;
    done_k = -1; n_acc = 0; n_clr = 0; n_resw = 0; n_act_ok = 0; n_w6 = 0;
    prev_rd = 0; prev_rw = 0; sv = 0; sr = 0;
    wseq.delete(); rseq.delete();
    rl[i] = relu0; st[i] = 1'b1; mv[i] = 1'b1; rr[i] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < budget; k++) begin
      #1;
      if (k == 0 && !hold_st) st[i] = 1'b0;
      if (k == 3) rl[i] = ~relu0;
      o = obs(i);
      if (o.mem_rd == 1 && !prev_rd) wseq.push_back(int'(o.w_addr));
      if (o.mem_rd == 1 && o.w_addr == 6) n_w6++;
      if (o.res_write == 1 && !prev_rw) rseq.push_back(int'(o.res_addr));
      if (o.res_write == 1) begin
        n_resw++;
        if (o.act_en == 32'(relu0)) n_act_ok++;
      end
      if (o.acc_write == 1) n_acc++;
      if (o.clear_acc == 1) n_clr++;
      if (do_stall) begin
        mv[i] = !(o.mem_rd == 1 && o.w_addr == 6 && sv < 3);
        if (!mv[i]) sv++;
        rr[i] = !(o.res_write == 1 && o.res_addr == 0 && sr < 2);
        if (!rr[i]) sr++;
      end
      if (o.done == 1) begin
        done_k = k;
        break;
      end
      prev_rd = o.mem_rd[0];
      prev_rw = o.res_write[0];
      @(posedge clk);
    end
    mv[i] = 1'b1; rr[i] = 1'b1;
  endtask

  initial begin
    int dk, na, nc, nrw, nak, nw6, found;
    int rcnt [NI];
    outs_t o;

    // Reset held with st high: everything stays zero.
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      o = obs(i);
      chk("rst_busy", i, o.busy, 0);
      chk("rst_mem_rd", i, o.mem_rd, 0);
      chk("rst_w_addr", i, o.w_addr, 0);
    end
    st = '0;
    tick();
    rstn = '1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) chk("idle_busy", i, obs(i).busy, 0);

    // D=4 Q=2, no stalls.
    run_layer(0, 1'b0, 1'b0, 1'b0, 60, dk, na, nc, nrw, nak, nw6);
    chk("done_cycle", 0, dk, 20);
    chk("acc_pulses", 0, na, 8);
    chk("clr_pulses", 0, nc, 2);
    chk("wseq_len", 0, wseq.size(), 8);
    for (int j = 0; j < 8 && j < wseq.size(); j++) chk("wseq", 0, wseq[j], j);
    chk("rseq_len", 0, rseq.size(), 2);
    for (int j = 0; j < 2 && j < rseq.size(); j++) chk("rseq", 0, rseq[j], j);
    chk("act_off", 0, nak, 2);
    tick();
    chk("busy_fall", 0, obs(0).busy, 0);

    // Stalls: 3 memory waits at w_addr 6, 2 sink waits on neuron 0.
    run_layer(0, 1'b1, 1'b0, 1'b1, 60, dk, na, nc, nrw, nak, nw6);
    chk("stall_done", 0, dk, 25);
    chk("stall_w6", 0, nw6, 4);
    chk("stall_resw", 0, nrw, 4);
    chk("stall_act_on", 0, nak, 4);
    chk("stall_acc", 0, na, 8);
    tick();

    // relu_en=0 latched, flipped mid-layer.
    run_layer(0, 1'b0, 1'b0, 1'b0, 60, dk, na, nc, nrw, nak, nw6);
    chk("act_off_again", 0, nak, 2);
    chk("done_again", 0, dk, 20);
    tick();

    // D=1 Q=1 with st held high throughout.
    run_layer(1, 1'b1, 1'b1, 1'b0, 20, dk, na, nc, nrw, nak, nw6);
    chk("d1q1_done", 1, dk, 4);
    chk("d1q1_wseq", 1, wseq.size() == 1 ? wseq[0] : -1, 0);
    tick();
    chk("d1q1_idle", 1, obs(1).busy, 0);
    tick();
    chk("d1q1_restart_busy", 1, obs(1).busy, 1);
    chk("d1q1_restart_rd", 1, obs(1).mem_rd, 1);
    st[1] = 1'b0;
    repeat (8) tick();
    chk("d1q1_settled", 1, obs(1).busy, 0);

    // Default-sized layer.
    run_layer(2, 1'b1, 1'b0, 1'b0, 200, dk, na, nc, nrw, nak, nw6);
    chk("big_done", 2, dk, 136);
    chk("big_acc", 2, na, 64);
    chk("big_clr", 2, nc, 4);
    tick();

    // Abort mid-layer at q=1, d=2.
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      o = obs(0);
      if (o.mem_rd == 1 && o.w_addr == 6) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("abort_reached", 0, found, 1);
    rstn[0] = 1'b0;
    #1;
    o = obs(0);
    chk("abort_busy", 0, o.busy, 0);
    chk("abort_mem_rd", 0, o.mem_rd, 0);
    chk("abort_w_addr", 0, o.w_addr, 0);
    chk("abort_x_addr", 0, o.x_addr, 0);
    chk("abort_done", 0, o.done, 0);
    repeat (2) tick();
    rstn[0] = 1'b1;
    tick();
    run_layer(0, 1'b0, 1'b0, 1'b0, 60, dk, na, nc, nrw, nak, nw6);
    chk("after_abort_w0", 0, wseq.size() > 0 ? wseq[0] : -1, 0);
    chk("after_abort_done", 0, dk, 20);
    tick();

    // Randomized traffic on all instances, checked by the model each cycle.
    for (int i = 0; i < NI; i++) rcnt[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (rcnt[i] > 0) begin
          rcnt[i]--;
          if (rcnt[i] == 0) rstn[i] = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          rstn[i] = 1'b0;
          rcnt[i] = int'($urandom_range(1, 3));
        end
        st[i] = ($urandom_range(0, 3) == 0);
        rl[i] = ($urandom_range(0, 1) == 1);
        mv[i] = ($urandom_range(0, 3) != 0);
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rstn = '1;
    st = '0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
